stateful_ram_sched: RTL and testbench

// - Sequences all accesses to one stage's 32x32 stateful data RAM and shares it between the ALU datapath and the control plane.
// - Datapath ops (load / store / load-increment) get tenant isolation through the page table {len,base}; control-plane reads and writes use absolute addresses.
// - One transaction in flight at a time; read-modify-write is atomic; the RAM is instantiated by the parent.

---
 rtl/stateful_ram_pkg.sv | 24 ++
 rtl/stateful_ram_sched_if.sv | 53 +++++
 rtl/stateful_ram_sched_arb.sv | 41 ++++
 rtl/stateful_ram_sched.sv | 163 ++++++++++++++++
 tb/tb_stateful_ram_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stateful_ram_pkg.sv
// Shared encodings for the stateful-RAM scheduler: datapath opcodes, FSM state codes
// and bit positions of the tenant page descriptor.
package stateful_ram_pkg;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'b00,
        OP_STORE   = 2'b01,
        OP_LOADINC = 2'b10,
        OP_RSVD    = 2'b11
    } dp_op_e;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_RSP     = 3'd4;

    localparam int PAGE_WIDTH    = 16;
    localparam int PAGE_LEN_MSB  = 15;
    localparam int PAGE_LEN_LSB  = 8;
    localparam int PAGE_BASE_MSB = 7;
    localparam int PAGE_BASE_LSB = 0;

endpackage

// File: rtl/stateful_ram_sched_if.sv
// Request/response handshakes for datapath and control plane plus the RAM port pins.
// master = parent side (requesters and RAM), slave = the scheduler.
interface stateful_ram_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    import stateful_ram_pkg::*;

    logic                  dp_req_valid;
    logic                  dp_req_ready;
    logic [1:0]            dp_req_op;
    logic [ADDR_WIDTH-1:0] dp_req_addr;
    logic [DATA_WIDTH-1:0] dp_req_wdata;
    logic [PAGE_WIDTH-1:0] dp_page;
    logic                  dp_rsp_valid;
    logic                  dp_rsp_ready;
    logic [DATA_WIDTH-1:0] dp_rsp_data;
    logic                  dp_rsp_ovf;

    logic                  cp_req_valid;
    logic                  cp_req_ready;
    logic                  cp_req_wr;
    logic [ADDR_WIDTH-1:0] cp_req_addr;
    logic [DATA_WIDTH-1:0] cp_req_wdata;
    logic                  cp_rsp_valid;
    logic                  cp_rsp_ready;
    logic [DATA_WIDTH-1:0] cp_rsp_data;

    logic                  ram_wea;
    logic [ADDR_WIDTH-1:0] ram_addra;
    logic [DATA_WIDTH-1:0] ram_dina;
    logic [ADDR_WIDTH-1:0] ram_addrb;
    logic [DATA_WIDTH-1:0] ram_doutb;

    modport master (
        output dp_req_valid, dp_req_op, dp_req_addr, dp_req_wdata, dp_page, dp_rsp_ready,
        input  dp_req_ready, dp_rsp_valid, dp_rsp_data, dp_rsp_ovf,
        output cp_req_valid, cp_req_wr, cp_req_addr, cp_req_wdata, cp_rsp_ready,
        input  cp_req_ready, cp_rsp_valid, cp_rsp_data,
        input  ram_wea, ram_addra, ram_dina, ram_addrb,
        output ram_doutb
    );

    modport slave (
        input  dp_req_valid, dp_req_op, dp_req_addr, dp_req_wdata, dp_page, dp_rsp_ready,
        output dp_req_ready, dp_rsp_valid, dp_rsp_data, dp_rsp_ovf,
        input  cp_req_valid, cp_req_wr, cp_req_addr, cp_req_wdata, cp_rsp_ready,
        output cp_req_ready, cp_rsp_valid, cp_rsp_data,
        output ram_wea, ram_addra, ram_dina, ram_addrb,
        input  ram_doutb
    );

endinterface

// File: rtl/stateful_ram_sched_arb.sv
// IDLE-time grant between datapath and control plane. DP normally wins; a waiting CP
// request is forced through once it has lost CP_MAX_WAIT IDLE cycles.
module ram_grant_arb #(
    parameter int CP_MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_idle,
    input  logic dp_valid,
    input  logic cp_valid,
    output logic dp_grant,
    output logic cp_grant
);

    localparam int CW = $clog2(CP_MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(CP_MAX_WAIT);

    logic [CW-1:0] starve_cnt;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cp_grant = 1'b0;
        dp_grant = 1'b0;
        if (in_idle) begin
            cp_grant = cp_valid && (!dp_valid || starve_cnt == WAIT_MAX);
            dp_grant = dp_valid && !cp_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (cp_grant) begin
            starve_cnt <= '0;
        end else if (in_idle && cp_valid && starve_cnt != WAIT_MAX) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/stateful_ram_sched.sv
// Single-transaction sequencer for one stage's stateful data RAM, shared by the ALU
// datapath (page-relative, with load-increment RMW) and the control plane (absolute).
module stateful_ram_sched
    import stateful_ram_pkg::*;
#(
    parameter int STAGE_ID    = 0,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int CP_MAX_WAIT = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    stateful_ram_sched_if.slave bus
);

    logic [2:0]            state;
    logic                  is_cp;
    logic                  is_inc;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] captured;

    logic                  dp_grant;
    logic                  cp_grant;
    logic                  in_idle;
    dp_op_e                dp_op;
    logic [7:0]            page_len;
    logic [7:0]            page_base;
    logic                  dp_ovf;
    logic [ADDR_WIDTH-1:0] dp_abs;
    logic [DATA_WIDTH-1:0] inc_val;
    logic                  rsp_done;

    // Stage index has no function here; kept as a named net for debug probing.
    logic [7:0] unused_stage_id;
    assign unused_stage_id = 8'(STAGE_ID);

    assign in_idle = (state == ST_IDLE);

    ram_grant_arb #(.CP_MAX_WAIT(CP_MAX_WAIT)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_idle  (in_idle),
        .dp_valid (bus.dp_req_valid),
        .cp_valid (bus.cp_req_valid),
        .dp_grant (dp_grant),
        .cp_grant (cp_grant)
    );

    assign bus.dp_req_ready = dp_grant;
    assign bus.cp_req_ready = cp_grant;

    // Tenant translation: strict range check, base offset wraps within the RAM depth.
    always_comb begin
        dp_op     = dp_op_e'(bus.dp_req_op);
        page_len  = bus.dp_page[PAGE_LEN_MSB:PAGE_LEN_LSB];
        page_base = bus.dp_page[PAGE_BASE_MSB:PAGE_BASE_LSB];
        dp_ovf    = int'(bus.dp_req_addr) > int'(page_len);
        dp_abs    = ADDR_WIDTH'(page_base) + bus.dp_req_addr;
        inc_val   = bus.ram_doutb + DATA_WIDTH'(1);
        rsp_done  = (bus.dp_rsp_valid && bus.dp_rsp_ready) ||
                    (bus.cp_rsp_valid && bus.cp_rsp_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            is_cp            <= 1'b0;
            is_inc           <= 1'b0;
            addr_q           <= '0;
            captured         <= '0;
            bus.dp_rsp_valid <= 1'b0;
            bus.dp_rsp_data  <= '0;
            bus.dp_rsp_ovf   <= 1'b0;
            bus.cp_rsp_valid <= 1'b0;
            bus.cp_rsp_data  <= '0;
            bus.ram_wea      <= 1'b0;
            bus.ram_addra    <= '0;
            bus.ram_dina     <= '0;
            bus.ram_addrb    <= '0;
        end else begin
            bus.ram_wea <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cp_grant) begin
                        is_cp  <= 1'b1;
                        is_inc <= 1'b0;
                        addr_q <= bus.cp_req_addr;
                        if (bus.cp_req_wr) begin
                            bus.ram_wea   <= 1'b1;
                            bus.ram_addra <= bus.cp_req_addr;
                            bus.ram_dina  <= bus.cp_req_wdata;
                            state         <= ST_WRITE;
                        end else begin
                            bus.ram_addrb <= bus.cp_req_addr;
                            state         <= ST_ISSUE;
                        end
                    end else if (dp_grant) begin
                        is_cp  <= 1'b0;
                        is_inc <= 1'b0;
                        addr_q <= dp_abs;
                        if (dp_ovf) begin
                            // Out-of-range tenant access answers immediately, RAM untouched.
                            bus.dp_rsp_valid <= 1'b1;
                            bus.dp_rsp_data  <= '0;
                            bus.dp_rsp_ovf   <= 1'b1;
                            state            <= ST_RSP;
                        end else if (dp_op == OP_STORE) begin
                            bus.ram_wea   <= 1'b1;
                            bus.ram_addra <= dp_abs;
                            bus.ram_dina  <= bus.dp_req_wdata;
                            state         <= ST_WRITE;
                        end else begin
                            is_inc        <= (dp_op == OP_LOADINC);
                            bus.ram_addrb <= dp_abs;
                            state         <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    if (is_inc) begin
                        // RMW stays atomic: no grant is possible until this write completes.
                        captured      <= inc_val;
                        bus.ram_wea   <= 1'b1;
                        bus.ram_addra <= addr_q;
                        bus.ram_dina  <= inc_val;
                        state         <= ST_WRITE;
                    end else begin
                        if (is_cp) begin
                            bus.cp_rsp_valid <= 1'b1;
                            bus.cp_rsp_data  <= bus.ram_doutb;
                        end else begin
                            bus.dp_rsp_valid <= 1'b1;
                            bus.dp_rsp_data  <= bus.ram_doutb;
                            bus.dp_rsp_ovf   <= 1'b0;
                        end
                        state <= ST_RSP;
                    end
                end
                ST_WRITE: begin
                    if (is_cp) begin
                        bus.cp_rsp_valid <= 1'b1;
                        bus.cp_rsp_data  <= '0;
                    end else begin
                        bus.dp_rsp_valid <= 1'b1;
                        bus.dp_rsp_data  <= is_inc ? captured : '0;
                        bus.dp_rsp_ovf   <= 1'b0;
                    end
                    state <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_done) begin
                        bus.dp_rsp_valid <= 1'b0;
                        bus.cp_rsp_valid <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stateful_ram_sched.sv
// Scoreboard bench: a reference memory predicts each response and RAM write at accept
// time; monitors compare data, latency and write timing when the DUT produces them.
module tb_stateful_ram_sched;
    import stateful_ram_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int MAXW  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    stateful_ram_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    stateful_ram_sched #(
        .STAGE_ID    (0),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .CP_MAX_WAIT (MAXW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (bus.ram_wea) ram[bus.ram_addra] <= bus.ram_dina;
        bus.ram_doutb <= ram[bus.ram_addrb];
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          ovf;
        int            acc;
        int            lat;
    } rsp_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wea_exp_t;

    rsp_exp_t dp_q[$];
    rsp_exp_t cp_q[$];
    wea_exp_t wea_q[$];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int wea_cnt = 0;
    logic dp_prev = 1'b0;
    logic cp_prev = 1'b0;
    rsp_exp_t mon_e;
    wea_exp_t mon_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_dp();
        rsp_exp_t e;
        wea_exp_t w;
        logic [7:0] len;
        logic [7:0] base;
        int abs_a;
        len   = bus.dp_page[15:8];
        base  = bus.dp_page[7:0];
        abs_a = (int'(base) + int'(bus.dp_req_addr)) % DEPTH;
        e.acc = cyc + 1;
        e.ovf = 1'b0;
        if (int'(bus.dp_req_addr) > int'(len)) begin
            e.data = '0;
            e.ovf  = 1'b1;
            e.lat  = 1;
        end else if (bus.dp_req_op == 2'b01) begin
            ref_mem[abs_a] = bus.dp_req_wdata;
            e.data = '0;
            e.lat  = 2;
            w.addr = AW'(abs_a);
            w.data = bus.dp_req_wdata;
            w.cyc  = e.acc;
            wea_q.push_back(w);
        end else if (bus.dp_req_op == 2'b10) begin
            ref_mem[abs_a] = ref_mem[abs_a] + 32'd1;
            e.data = ref_mem[abs_a];
            e.lat  = 4;
            w.addr = AW'(abs_a);
            w.data = ref_mem[abs_a];
            w.cyc  = e.acc + 2;
            wea_q.push_back(w);
        end else begin
            e.data = ref_mem[abs_a];
            e.lat  = 3;
        end
        dp_q.push_back(e);
    endtask

    task automatic model_cp();
        rsp_exp_t e;
        wea_exp_t w;
        e.acc = cyc + 1;
        e.ovf = 1'b0;
        if (bus.cp_req_wr) begin
            ref_mem[bus.cp_req_addr] = bus.cp_req_wdata;
            e.data = '0;
            e.lat  = 2;
            w.addr = bus.cp_req_addr;
            w.data = bus.cp_req_wdata;
            w.cyc  = e.acc;
            wea_q.push_back(w);
        end else begin
            e.data = ref_mem[bus.cp_req_addr];
            e.lat  = 3;
        end
        cp_q.push_back(e);
    endtask

    // Accept, write and response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dp_req_valid && bus.dp_req_ready) model_dp();
            if (bus.cp_req_valid && bus.cp_req_ready) model_cp();
            if (bus.ram_wea) begin
                wea_cnt++;
                if (wea_q.size() == 0) begin
                    check("wea_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_w = wea_q.pop_front();
                    check("wea_addr", 32'(bus.ram_addra), 32'(mon_w.addr));
                    check("wea_data", bus.ram_dina, mon_w.data);
                    check("wea_cycle", 32'(cyc), 32'(mon_w.cyc));
                end
            end
            if (bus.dp_rsp_valid && !dp_prev) begin
                if (dp_q.size() == 0) begin
                    check("dp_rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = dp_q[0];
                    check("dp_latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                    check("dp_data", bus.dp_rsp_data, mon_e.data);
                    check("dp_ovf", 32'(bus.dp_rsp_ovf), 32'(mon_e.ovf));
                end
            end
            if (bus.cp_rsp_valid && !cp_prev) begin
                if (cp_q.size() == 0) begin
                    check("cp_rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = cp_q[0];
                    check("cp_latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                    check("cp_data", bus.cp_rsp_data, mon_e.data);
                end
            end
            if (bus.dp_rsp_valid && bus.dp_rsp_ready && dp_q.size() > 0) void'(dp_q.pop_front());
            if (bus.cp_rsp_valid && bus.cp_rsp_ready && cp_q.size() > 0) void'(cp_q.pop_front());
        end
        dp_prev = bus.dp_rsp_valid;
        cp_prev = bus.cp_rsp_valid;
    end

    task automatic wait_rsp(input bit for_cp);
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (for_cp ? (bus.cp_rsp_valid && bus.cp_rsp_ready)
                       : (bus.dp_rsp_valid && bus.dp_rsp_ready)) break;
        end
        check(for_cp ? "cp_rsp_seen" : "dp_rsp_seen", 32'(n < 60), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic dp_go(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [15:0] page, input bit wait_done);
        int n;
        bus.dp_req_valid = 1'b1;
        bus.dp_req_op    = op;
        bus.dp_req_addr  = addr;
        bus.dp_req_wdata = wd;
        bus.dp_page      = page;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.dp_req_ready) break;
        end
        check("dp_accept", 32'(n < 40), 32'd1);
        @(posedge clk);
        #1;
        bus.dp_req_valid = 1'b0;
        if (wait_done) wait_rsp(1'b0);
    endtask

    task automatic cp_go(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n;
        bus.cp_req_valid = 1'b1;
        bus.cp_req_wr    = wr;
        bus.cp_req_addr  = addr;
        bus.cp_req_wdata = wd;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.cp_req_ready) break;
        end
        check("cp_accept", 32'(n < 40), 32'd1);
        @(posedge clk);
        #1;
        bus.cp_req_valid = 1'b0;
        wait_rsp(1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wea"},      32'(bus.ram_wea), 32'd0);
        check({tag, "_addra"},    32'(bus.ram_addra), 32'd0);
        check({tag, "_dina"},     bus.ram_dina, 32'd0);
        check({tag, "_addrb"},    32'(bus.ram_addrb), 32'd0);
        check({tag, "_dp_valid"}, 32'(bus.dp_rsp_valid), 32'd0);
        check({tag, "_dp_data"},  bus.dp_rsp_data, 32'd0);
        check({tag, "_dp_ovf"},   32'(bus.dp_rsp_ovf), 32'd0);
        check({tag, "_cp_valid"}, 32'(bus.cp_rsp_valid), 32'd0);
        check({tag, "_cp_data"},  bus.cp_rsp_data, 32'd0);
        check({tag, "_readies"},  32'({bus.dp_req_ready, bus.cp_req_ready}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p1;
        logic [15:0] p2;
        int base_cnt;
        int n_dp;
        int n;

        p1 = {8'd4, 8'd8};
        p2 = {8'd31, 8'd30};
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        bus.dp_req_valid = 1'b0;
        bus.dp_req_op    = 2'b00;
        bus.dp_req_addr  = '0;
        bus.dp_req_wdata = '0;
        bus.dp_page      = '0;
        bus.dp_rsp_ready = 1'b1;
        bus.cp_req_valid = 1'b0;
        bus.cp_req_wr    = 1'b0;
        bus.cp_req_addr  = '0;
        bus.cp_req_wdata = '0;
        bus.cp_rsp_ready = 1'b1;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // CP write then read back at an absolute address.
        cp_go(1'b1, 5'd11, 32'h1234_5678);
        cp_go(1'b0, 5'd11, '0);

        // Page {len=4, base=8}: store to tenant addr 3 lands at absolute 11.
        dp_go(2'b01, 5'd3, 32'h0000_00AB, p1, 1'b1);
        dp_go(2'b00, 5'd3, '0, p1, 1'b1);

        // Load-increment wraps the all-ones word to zero.
        cp_go(1'b1, 5'd11, 32'hFFFF_FFFF);
        dp_go(2'b10, 5'd3, '0, p1, 1'b1);
        cp_go(1'b0, 5'd11, '0);

        // Out-of-range address: immediate overflow, no RAM write.
        base_cnt = wea_cnt;
        dp_go(2'b00, 5'd5, '0, p1, 1'b1);
        check("ovf_no_wea", 32'(wea_cnt), 32'(base_cnt));
        dp_go(2'b10, 5'd7, '0, p1, 1'b1);
        check("ovf_inc_no_wea", 32'(wea_cnt), 32'(base_cnt));

        // addr == len is still in range.
        dp_go(2'b00, 5'd4, '0, p1, 1'b1);
        dp_go(2'b10, 5'd0, '0, p1, 1'b1);

        // Reserved opcode behaves as a load.
        base_cnt = wea_cnt;
        dp_go(2'b11, 5'd2, '0, p1, 1'b1);
        check("rsvd_no_wea", 32'(wea_cnt), 32'(base_cnt));

        // Base 30 + addr 3 wraps to absolute 1.
        dp_go(2'b01, 5'd3, 32'h0000_0055, p2, 1'b1);
        cp_go(1'b0, 5'd1, '0);

        // Response back-pressure: held stable, no new accept while a request waits.
        bus.dp_rsp_ready = 1'b0;
        dp_go(2'b00, 5'd3, '0, p2, 1'b0);
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.dp_rsp_valid) break;
        end
        check("hold_rsp_seen", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        bus.dp_req_valid = 1'b1;
        bus.dp_req_op    = 2'b00;
        bus.dp_req_addr  = 5'd2;
        bus.dp_page      = p1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.dp_rsp_valid), 32'd1);
            check("hold_data", bus.dp_rsp_data, 32'h0000_0055);
            check("hold_no_accept", 32'(bus.dp_req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.dp_rsp_ready = 1'b1;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.dp_req_ready) break;
        end
        check("hold_next_accept", 32'(n < 40), 32'd1);
        @(posedge clk);
        #1;
        bus.dp_req_valid = 1'b0;
        wait_rsp(1'b0);

        // Starvation: DP held valid, CP read wins after exactly MAXW lost IDLE cycles.
        cp_go(1'b1, 5'd20, 32'h0000_CAFE);
        bus.cp_req_valid = 1'b1;
        bus.cp_req_wr    = 1'b0;
        bus.cp_req_addr  = 5'd20;
        bus.dp_req_valid = 1'b1;
        bus.dp_req_op    = 2'b00;
        bus.dp_req_addr  = 5'd1;
        bus.dp_page      = {8'd31, 8'd0};
        n_dp = 0;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.dp_req_ready) n_dp++;
            if (bus.cp_req_ready) break;
        end
        check("starve_cp_granted", 32'(n < 400), 32'd1);
        check("starve_dp_wins", 32'(n_dp), 32'(MAXW));
        @(posedge clk);
        #1;
        bus.cp_req_valid = 1'b0;
        bus.dp_req_valid = 1'b0;
        wait_rsp(1'b1);

        // Reset in the middle of a load aborts it silently.
        base_cnt = wea_cnt;
        dp_go(2'b00, 5'd2, '0, p1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        dp_q.delete();
        cp_q.delete();
        wea_q.delete();
        check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_no_wea", 32'(wea_cnt), 32'(base_cnt));
        dp_go(2'b00, 5'd2, '0, p1, 1'b1);
        dp_go(2'b01, 5'd1, 32'h0000_0077, p1, 1'b1);
        cp_go(1'b0, 5'd9, '0);

        repeat (3) @(posedge clk);
        #1;
        check("dp_q_drained", 32'(dp_q.size()), 32'd0);
        check("cp_q_drained", 32'(cp_q.size()), 32'd0);
        check("wea_q_drained", 32'(wea_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
